afc_cal_sequencer: RTL

Sequencer that drives the 4-channel PLL automatic-frequency-calibration block: walks through enabled channels, selects each one, pulses `AFCstart`, waits for `AFCbusy` to complete and stores the resulting 6-bit code as that channel's override value. Between and after runs it holds `overridecontrol` high so every channel runs from its stored code. It sits between the I2C/slow-control register bank and the AFC block, replacing per-channel manual calibration.

---
 rtl/afc_cal_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/afc_cal_sequencer.sv
// ============================================================================
// afc_cal_sequencer : walks enabled PLL channels through AFC calibration and
//                     keeps every channel on its stored override code.
// Optional: define AFC_SEQ_RETRY_EN to retry a timed-out channel once.
// Rev 1.0
// ============================================================================
`default_nettype none

module afc_cal_sequencer #(
    parameter int SETTLE_CYCLES  = 64,
    parameter int START_LEN      = 4,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic       extCLK40,
    input  logic       reset,
    input  logic       calStart,
    input  logic [3:0] chEnable,
    input  logic       calSourceIn,
    input  logic       AFCbusy,
    input  logic [5:0] calControlCode,
    output logic [1:0] calChSel,
    output logic       calSource,
    output logic       AFCstart,
    output logic       overridecontrol,
    output logic [5:0] overridecontrol_val1,
    output logic [5:0] overridecontrol_val2,
    output logic [5:0] overridecontrol_val3,
    output logic [5:0] overridecontrol_val4,
    output logic       seqBusy,
    output logic       seqDone,
    output logic [3:0] calError
);

    localparam logic [7:0]  C_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] C_START_LAST  = 16'(START_LEN - 1);
    localparam logic [15:0] C_TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]  C_CODE_RESET  = 6'd32;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SELECT    = 3'd1,
        S_START     = 3'd2,
        S_WAIT_RISE = 3'd3,
        S_WAIT_FALL = 3'd4,
        S_CAPTURE   = 3'd5,
        S_NEXT      = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_busy_meta;
    logic        r_busy_sync;
    logic        r_busy_seen;
    logic [3:0]  r_en;
    logic        r_ptr_valid;
    logic [7:0]  r_settle_cnt;
    logic [15:0] r_tmo_cnt;
    logic [5:0]  r_val [4];

    logic        w_latch;
    logic        w_load_ch;
    logic        w_capture;
    logic        w_tmo_fire;
    logic        w_tmo_err;
    logic        w_found;
    logic [1:0]  w_next_ch;

`ifdef AFC_SEQ_RETRY_EN
    logic        r_retried;
    logic        w_retry;

    always_ff @(posedge extCLK40) begin
        if (reset || w_load_ch) begin
            r_retried <= 1'b0;
        end else if (w_retry) begin
            r_retried <= 1'b1;
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_load_ch    = 1'b0;
        w_capture    = 1'b0;
        w_tmo_fire   = 1'b0;
        w_tmo_err    = 1'b0;
        w_found      = 1'b0;
        w_next_ch    = 2'd0;
`ifdef AFC_SEQ_RETRY_EN
        w_retry      = 1'b0;
`endif
        // Descending scan leaves the lowest qualifying channel selected.
        for (int k = 3; k >= 0; k--) begin
            if (r_en[k] && (!r_ptr_valid || (2'(k) > calChSel))) begin
                w_found   = 1'b1;
                w_next_ch = 2'(k);
            end
        end
        case (r_state)
            S_IDLE: begin
                if (calStart) begin
                    w_latch      = 1'b1;
                    w_next_state = S_NEXT;
                end
            end
            S_NEXT: begin
                if (w_found) begin
                    w_load_ch    = 1'b1;
                    w_next_state = S_SELECT;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_SELECT: begin
                if (r_settle_cnt == C_SETTLE_LAST) w_next_state = S_START;
            end
            S_START: begin
                if (r_tmo_cnt == C_TMO_LAST)        w_tmo_fire   = 1'b1;
                else if (r_tmo_cnt == C_START_LAST) w_next_state = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (r_busy_sync || r_busy_seen)   w_next_state = S_WAIT_FALL;
                else if (r_tmo_cnt == C_TMO_LAST) w_tmo_fire   = 1'b1;
            end
            S_WAIT_FALL: begin
                if (!r_busy_sync)                 w_next_state = S_CAPTURE;
                else if (r_tmo_cnt == C_TMO_LAST) w_tmo_fire   = 1'b1;
            end
            S_CAPTURE: begin
                w_capture    = 1'b1;
                w_next_state = S_NEXT;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (w_tmo_fire) begin
`ifdef AFC_SEQ_RETRY_EN
            if (!r_retried) begin
                w_retry      = 1'b1;
                w_next_state = S_SELECT;
            end else begin
                w_tmo_err    = 1'b1;
                w_next_state = S_NEXT;
            end
`else
            w_tmo_err    = 1'b1;
            w_next_state = S_NEXT;
`endif
        end
    end

    always_ff @(posedge extCLK40) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_busy_meta  <= 1'b0;
            r_busy_sync  <= 1'b0;
            r_busy_seen  <= 1'b0;
            r_en         <= 4'd0;
            r_ptr_valid  <= 1'b0;
            r_settle_cnt <= 8'd0;
            r_tmo_cnt    <= 16'd0;
            calChSel     <= 2'd0;
            calSource    <= 1'b0;
            calError     <= 4'd0;
            for (int k = 0; k < 4; k++) r_val[k] <= C_CODE_RESET;
        end else begin
            r_state      <= w_next_state;
            r_busy_meta  <= AFCbusy;
            r_busy_sync  <= r_busy_meta;
            r_settle_cnt <= (r_state == S_SELECT) ? r_settle_cnt + 8'd1 : 8'd0;
            // Attempt timer spans START through WAIT_FALL; SELECT rearms it.
            if (r_state == S_START || r_state == S_WAIT_RISE || r_state == S_WAIT_FALL)
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            else
                r_tmo_cnt <= 16'd0;
            if (r_state == S_SELECT)
                r_busy_seen <= 1'b0;
            else if (r_state == S_START && r_busy_sync)
                r_busy_seen <= 1'b1;
            if (w_latch) begin
                r_en        <= chEnable;
                calSource   <= calSourceIn;
                calError    <= 4'd0;
                r_ptr_valid <= 1'b0;
            end
            if (w_load_ch) begin
                calChSel    <= w_next_ch;
                r_ptr_valid <= 1'b1;
            end
            if (w_capture) r_val[calChSel] <= calControlCode;
            if (w_tmo_err) calError[calChSel] <= 1'b1;
        end
    end

    always_comb begin
        AFCstart        = (r_state == S_START);
        seqDone         = (r_state == S_DONE);
        seqBusy         = (r_state != S_IDLE) && (r_state != S_DONE);
        overridecontrol = (r_state == S_IDLE) || (r_state == S_NEXT) || (r_state == S_DONE);
    end

    assign overridecontrol_val1 = r_val[0];
    assign overridecontrol_val2 = r_val[1];
    assign overridecontrol_val3 = r_val[2];
    assign overridecontrol_val4 = r_val[3];

endmodule

`default_nettype wire
